// File: rtl/des_feistel_core.sv
// Iterative DES Feistel engine between IP and FP: NUM_ROUNDS rounds, UNROLL rounds per clock,
// subkeys fetched from an external schedule via key_idx, valid/ready on both sides.
module des_feistel_core #(
    parameter int NUM_ROUNDS = 16,
    parameter int UNROLL     = 1,
    parameter int IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_decrypt,
    input  logic [31:0]             in_L,
    input  logic [31:0]             in_R,
    output logic [IDX_W-1:0]        key_idx,
    input  logic [48*UNROLL-1:0]    subkey,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_L,
    output logic [31:0]             out_R,
    output logic                    busy
);

    if ((NUM_ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("des_feistel_core: NUM_ROUNDS must be a multiple of UNROLL");
    end

    // S-box i, entry 0 in the top nibble; entry index = {b1, b6, b2..b5}
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    localparam logic [IDX_W:0]   STEP     = (IDX_W+1)'(UNROLL);
    localparam logic [IDX_W:0]   NR       = (IDX_W+1)'(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W:0]   cnt;
    logic [IDX_W:0]   cnt_nxt;
    logic             last;
    logic [31:0]      l_q, r_q;
    logic             dir_q;
    logic [31:0]      l_new, r_new;

    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        logic [31:0] l_i, r_i, l_o, r_o, s_out, f_out;
        logic [47:0] x;

        if (j == 0) begin : g_src
            assign l_i = l_q;
            assign r_i = r_q;
        end else begin : g_src
            assign l_i = g_round[j-1].l_o;
            assign r_i = g_round[j-1].r_o;
        end

        // E expansion of R (DES bit 1 = MSB), mixed with this slot's subkey
        assign x = {r_i[0], r_i[31:27], r_i[28:23], r_i[24:19], r_i[20:15],
                    r_i[16:11], r_i[12:7], r_i[8:3], r_i[4:0], r_i[31]} ^ subkey[48*j +: 48];

        for (genvar i = 0; i < 8; i++) begin : g_sbox
            logic [5:0] b;
            assign b = x[47-6*i -: 6];
            assign s_out[31-4*i -: 4] = SBOX[i][8'd255 - {b[5], b[0], b[4:1], 2'b00} -: 4];
        end

        assign f_out = {s_out[16], s_out[25], s_out[12], s_out[11], s_out[3],  s_out[20], s_out[4],  s_out[15],
                        s_out[31], s_out[17], s_out[9],  s_out[6],  s_out[27], s_out[14], s_out[1],  s_out[22],
                        s_out[30], s_out[24], s_out[8],  s_out[18], s_out[0],  s_out[5],  s_out[29], s_out[23],
                        s_out[13], s_out[19], s_out[2],  s_out[26], s_out[10], s_out[21], s_out[28], s_out[7]};

        assign l_o = r_i;
        assign r_o = l_i ^ f_out;
    end

    assign l_new   = g_round[UNROLL-1].l_o;
    assign r_new   = g_round[UNROLL-1].r_o;
    assign cnt_nxt = cnt + STEP;
    assign last    = (cnt_nxt == NR);

    assign key_idx = (state != RUN) ? '0 :
                     dir_q          ? LAST_IDX - cnt[IDX_W-1:0] : cnt[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            l_q   <= '0;
            r_q   <= '0;
            dir_q <= 1'b0;
            out_L <= '0;
            out_R <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        l_q   <= in_L;
                        r_q   <= in_R;
                        dir_q <= in_decrypt;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    l_q <= l_new;
                    r_q <= r_new;
                    cnt <= cnt_nxt;
                    // final swap folded into the output register
                    if (last) begin
                        out_L <= r_new;
                        out_R <= l_new;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_des_feistel_core.sv
// Directed bench for des_feistel_core using the classic 133457799BBCDFF1 key schedule,
// with one UNROLL=1 and one UNROLL=4 instance sharing the stimulus bus.
module tb_des_feistel_core;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_decrypt, out_ready, sel, cur_dec;
    logic [31:0] in_L, in_R;

    logic             in_valid1, in_ready1, out_valid1, busy1;
    logic             in_valid4, in_ready4, out_valid4, busy4;
    logic [IDX_W-1:0] key_idx1, key_idx4;
    logic [47:0]      subkey1;
    logic [191:0]     subkey4;
    logic [31:0]      out_L1, out_R1, out_L4, out_R4;

    logic             in_ready_m, out_valid_m, busy_m;
    logic [IDX_W-1:0] key_idx_m;
    logic [31:0]      out_L_m, out_R_m;

    logic [47:0] ktab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    int tests = 0;
    int fails = 0;
    logic [IDX_W-1:0] klog [32];
    int nk;

    assign in_valid1 = in_valid & ~sel;
    assign in_valid4 = in_valid & sel;
    assign subkey1   = ktab[key_idx1];

    always_comb begin
        subkey4 = '0;
        for (int j = 0; j < 4; j++)
            subkey4[48*j +: 48] = ktab[cur_dec ? key_idx4 - 4'(j) : key_idx4 + 4'(j)];
    end

    assign in_ready_m  = sel ? in_ready4  : in_ready1;
    assign out_valid_m = sel ? out_valid4 : out_valid1;
    assign busy_m      = sel ? busy4      : busy1;
    assign key_idx_m   = sel ? key_idx4   : key_idx1;
    assign out_L_m     = sel ? out_L4     : out_L1;
    assign out_R_m     = sel ? out_R4     : out_R1;

    des_feistel_core #(.NUM_ROUNDS(16), .UNROLL(1), .IDX_W(IDX_W)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_decrypt(in_decrypt),
        .in_L(in_L), .in_R(in_R), .key_idx(key_idx1), .subkey(subkey1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_L(out_L1), .out_R(out_R1), .busy(busy1)
    );

    des_feistel_core #(.NUM_ROUNDS(16), .UNROLL(4), .IDX_W(IDX_W)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_decrypt(in_decrypt),
        .in_L(in_L), .in_R(in_R), .key_idx(key_idx4), .subkey(subkey4), .out_valid(out_valid4),
        .out_ready(out_ready), .out_L(out_L4), .out_R(out_R4), .busy(busy4)
    );

    // Offers one block, waits (bounded) for the accept edge, then scrambles the input bus.
    task automatic send(input logic dec, input logic [31:0] l, input logic [31:0] r, output int ok);
        int guard;
        guard = 0;
        cur_dec = dec; in_valid = 1'b1; in_decrypt = dec; in_L = l; in_R = r;
        while (in_ready_m !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        ok = (guard < 50) ? 1 : 0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_decrypt = ~dec; in_L = 32'hDEADBEEF; in_R = 32'h01234567;
    endtask

    // Latency counts the accept cycle as cycle 1; key_idx is logged once per RUN cycle.
    task automatic collect(output logic [31:0] ol, output logic [31:0] orr, output int lat);
        lat = 1; nk = 0;
        while (out_valid_m !== 1'b1 && lat < 100) begin
            if (nk < 32) klog[nk] = key_idx_m;
            nk++;
            @(posedge clk); #1; lat++;
        end
        ol = out_L_m; orr = out_R_m;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; cur_dec = 1'b0;
        in_decrypt = 1'b0; in_L = '0; in_R = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready1 !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready1); end
        tests++; if (out_valid1 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid1); end
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy1); end
        tests++; if (out_L1 !== 32'h0 || out_R1 !== 32'h0) begin fails++; $display("FAIL reset_out: got %h_%h want 0_0", out_L1, out_R1); end
        tests++; if (key_idx1 !== 4'd0) begin fails++; $display("FAIL reset_key_idx: got %0d want 0", key_idx1); end
        tests++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b0) begin fails++; $display("FAIL reset_dut4: got ov=%b ir=%b want 0 0", out_valid4, in_ready4); end
        rst = 1'b0; #1;
        tests++; if (in_ready1 !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready1); end
    endtask

    task automatic test_encrypt;
        int ok, lat; logic [31:0] ol, orr;
        sel = 1'b0; out_ready = 1'b1;
        send(1'b0, 32'hCC00CCFF, 32'hF0AAF0AA, ok);
        collect(ol, orr, lat);
        tests++; if (ok != 1) begin fails++; $display("FAIL enc_accept: got timeout want accept"); end
        tests++; if (lat != 17) begin fails++; $display("FAIL enc_latency: got %0d want 17", lat); end
        tests++; if (ol !== 32'h0A4CD995 || orr !== 32'h43423234) begin fails++; $display("FAIL enc_result: got %h_%h want 0a4cd995_43423234", ol, orr); end
        tests++; if (nk != 16) begin fails++; $display("FAIL enc_key_count: got %0d want 16", nk); end
        for (int i = 0; i < 16 && i < nk; i++) begin
            tests++; if (klog[i] !== 4'(i)) begin fails++; $display("FAIL enc_key_idx[%0d]: got %0d want %0d", i, klog[i], i); end
        end
    endtask

    task automatic test_decrypt;
        int ok, lat; logic [31:0] ol, orr;
        sel = 1'b0; out_ready = 1'b1;
        send(1'b1, 32'h0A4CD995, 32'h43423234, ok);
        collect(ol, orr, lat);
        tests++; if (ok != 1) begin fails++; $display("FAIL dec_accept: got timeout want accept"); end
        tests++; if (ol !== 32'hCC00CCFF || orr !== 32'hF0AAF0AA) begin fails++; $display("FAIL dec_result: got %h_%h want cc00ccff_f0aaf0aa", ol, orr); end
        tests++; if (nk != 16) begin fails++; $display("FAIL dec_key_count: got %0d want 16", nk); end
        for (int i = 0; i < 16 && i < nk; i++) begin
            tests++; if (klog[i] !== 4'(15 - i)) begin fails++; $display("FAIL dec_key_idx[%0d]: got %0d want %0d", i, klog[i], 15 - i); end
        end
    endtask

    task automatic test_unroll4;
        int ok, lat; logic [31:0] ol, orr;
        logic [3:0] enc_keys [4];
        logic [3:0] dec_keys [4];
        enc_keys = '{4'd0, 4'd4, 4'd8, 4'd12};
        dec_keys = '{4'd15, 4'd11, 4'd7, 4'd3};
        sel = 1'b1; out_ready = 1'b1;
        send(1'b0, 32'hCC00CCFF, 32'hF0AAF0AA, ok);
        collect(ol, orr, lat);
        tests++; if (ok != 1) begin fails++; $display("FAIL u4_enc_accept: got timeout want accept"); end
        tests++; if (lat != 5) begin fails++; $display("FAIL u4_latency: got %0d want 5", lat); end
        tests++; if (ol !== 32'h0A4CD995 || orr !== 32'h43423234) begin fails++; $display("FAIL u4_enc_result: got %h_%h want 0a4cd995_43423234", ol, orr); end
        tests++; if (nk != 4) begin fails++; $display("FAIL u4_enc_key_count: got %0d want 4", nk); end
        for (int i = 0; i < 4 && i < nk; i++) begin
            tests++; if (klog[i] !== enc_keys[i]) begin fails++; $display("FAIL u4_enc_key_idx[%0d]: got %0d want %0d", i, klog[i], enc_keys[i]); end
        end
        send(1'b1, 32'h0A4CD995, 32'h43423234, ok);
        collect(ol, orr, lat);
        tests++; if (ol !== 32'hCC00CCFF || orr !== 32'hF0AAF0AA) begin fails++; $display("FAIL u4_dec_result: got %h_%h want cc00ccff_f0aaf0aa", ol, orr); end
        for (int i = 0; i < 4 && i < nk; i++) begin
            tests++; if (klog[i] !== dec_keys[i]) begin fails++; $display("FAIL u4_dec_key_idx[%0d]: got %0d want %0d", i, klog[i], dec_keys[i]); end
        end
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic test_backpressure;
        int ok, lat; logic [31:0] ol, orr;
        sel = 1'b0; out_ready = 1'b0;
        send(1'b0, 32'hCC00CCFF, 32'hF0AAF0AA, ok);
        collect(ol, orr, lat);
        tests++; if (ol !== 32'h0A4CD995 || orr !== 32'h43423234) begin fails++; $display("FAIL bp_result: got %h_%h want 0a4cd995_43423234", ol, orr); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || out_L_m !== 32'h0A4CD995 || out_R_m !== 32'h43423234) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b out=%h_%h want ov=1 ir=0 out=0a4cd995_43423234", i, out_valid_m, in_ready_m, out_L_m, out_R_m);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin fails++; $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", out_valid_m, in_ready_m); end
    endtask

    task automatic test_reset_mid_run;
        int ok, lat, seen; logic [31:0] ol, orr;
        sel = 1'b0; out_ready = 1'b1;
        send(1'b0, 32'hCC00CCFF, 32'hF0AAF0AA, ok);
        repeat (6) @(posedge clk);
        #1;
        tests++; if (busy_m !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b want 1", busy_m); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_valid_m !== 1'b0 || busy_m !== 1'b0 || in_ready_m !== 1'b0 || key_idx_m !== 4'd0) begin
            fails++; $display("FAIL mid_reset: got ov=%b busy=%b ir=%b kidx=%0d want 0 0 0 0", out_valid_m, busy_m, in_ready_m, key_idx_m);
        end
        rst = 1'b0; #1;
        tests++; if (in_ready_m !== 1'b1) begin fails++; $display("FAIL mid_in_ready: got %b want 1", in_ready_m); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid_m === 1'b1) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL mid_no_output: got %0d valid cycles want 0", seen); end
        send(1'b1, 32'h0A4CD995, 32'h43423234, ok);
        collect(ol, orr, lat);
        tests++; if (ol !== 32'hCC00CCFF || orr !== 32'hF0AAF0AA || lat != 17) begin
            fails++; $display("FAIL mid_fresh_block: got %h_%h lat=%0d want cc00ccff_f0aaf0aa lat=17", ol, orr, lat);
        end
    endtask

    task automatic test_back_to_back;
        int guard, lat; logic [31:0] ol, orr;
        sel = 1'b0; out_ready = 1'b1; cur_dec = 1'b0;
        in_valid = 1'b1; in_decrypt = 1'b0; in_L = 32'hCC00CCFF; in_R = 32'hF0AAF0AA;
        guard = 0;
        while (in_ready_m !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        tests++; if (guard >= 50) begin fails++; $display("FAIL b2b_first_accept: got timeout want accept"); end
        @(posedge clk); #1;
        in_decrypt = 1'b1; in_L = 32'h0A4CD995; in_R = 32'h43423234;
        collect(ol, orr, lat);
        tests++; if (ol !== 32'h0A4CD995 || orr !== 32'h43423234 || lat != 17) begin
            fails++; $display("FAIL b2b_first: got %h_%h lat=%0d want 0a4cd995_43423234 lat=17", ol, orr, lat);
        end
        @(posedge clk); #1;
        tests++; if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin fails++; $display("FAIL b2b_gap: got ov=%b ir=%b want ov=0 ir=1", out_valid_m, in_ready_m); end
        @(posedge clk); #1;
        tests++; if (busy_m !== 1'b1) begin fails++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy_m); end
        in_valid = 1'b0;
        collect(ol, orr, lat);
        tests++; if (ol !== 32'hCC00CCFF || orr !== 32'hF0AAF0AA || lat != 17) begin
            fails++; $display("FAIL b2b_second: got %h_%h lat=%0d want cc00ccff_f0aaf0aa lat=17", ol, orr, lat);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_unroll4();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
